// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: holds one decoded instruction, resolves
// MEM/WB operand forwarding and load-use stalls, and feeds the ALU and MEM sideband.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [OPW-1:0]  in_alu_op,
  input  logic            in_src1_pc,
  input  logic            in_src2_imm,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            flush,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [XLEN-1:0] out_store_data,
  output logic [31:0]     stall_cnt
);

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
  logic [4:0]      rs1_addr_p1, rs2_addr_p1, rd_addr_p1;
  logic [OPW-1:0]  alu_op_p1;
  logic            src1_pc_p1, src2_imm_p1, reg_write_p1, mem_read_p1, mem_write_p1;
  logic [31:0]     stall_cnt_q;

  logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic            use1, use2, load_use, load, handoff;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    mem_hit1 = mem_reg_write && (mem_rd_addr == rs1_addr_p1) && (rs1_addr_p1 != 5'd0);
    mem_hit2 = mem_reg_write && (mem_rd_addr == rs2_addr_p1) && (rs2_addr_p1 != 5'd0);
    wb_hit1  = wb_reg_write  && (wb_rd_addr  == rs1_addr_p1) && (rs1_addr_p1 != 5'd0);
    wb_hit2  = wb_reg_write  && (wb_rd_addr  == rs2_addr_p1) && (rs2_addr_p1 != 5'd0);

    fwd_rs1 = mem_hit1 ? mem_result : (wb_hit1 ? wb_result : rs1_data_p1);
    fwd_rs2 = mem_hit2 ? mem_result : (wb_hit2 ? wb_result : rs2_data_p1);

    // A store still needs rs2 as its data even when operand 2 is the immediate.
    use1 = ~src1_pc_p1;
    use2 = ~(src2_imm_p1 & ~mem_write_p1);
    load_use = vld_p1 && mem_mem_read && mem_reg_write && (mem_rd_addr != 5'd0) &&
               ((use1 && (mem_rd_addr == rs1_addr_p1)) ||
                (use2 && (mem_rd_addr == rs2_addr_p1)));

    out_valid = vld_p1 & ~load_use;
    handoff   = out_valid & out_ready;
    in_ready  = ~vld_p1 | handoff;
    load      = in_valid & in_ready;
  end

  assign alu_in1        = src1_pc_p1  ? pc_p1  : fwd_rs1;
  assign alu_in2        = src2_imm_p1 ? imm_p1 : fwd_rs2;
  assign out_store_data = fwd_rs2;
  assign alu_op         = alu_op_p1;
  assign out_pc         = pc_p1;
  assign out_rd_addr    = rd_addr_p1;
  assign out_reg_write  = reg_write_p1;
  assign out_mem_read   = mem_read_p1;
  assign out_mem_write  = mem_write_p1;
  assign stall_cnt      = stall_cnt_q;

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      alu_op_p1    <= '0;
      src1_pc_p1   <= 1'b0;
      src2_imm_p1  <= 1'b0;
      rd_addr_p1   <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      if (flush)        vld_p1 <= 1'b0;
      else if (load)    vld_p1 <= 1'b1;
      else if (handoff) vld_p1 <= 1'b0;

      if (load && !flush) begin
        pc_p1        <= in_pc;
        rs1_addr_p1  <= in_rs1_addr;
        rs2_addr_p1  <= in_rs2_addr;
        rs1_data_p1  <= in_rs1_data;
        rs2_data_p1  <= in_rs2_data;
        imm_p1       <= in_imm;
        alu_op_p1    <= in_alu_op;
        src1_pc_p1   <= in_src1_pc;
        src2_imm_p1  <= in_src2_imm;
        rd_addr_p1   <= in_rd_addr;
        reg_write_p1 <= in_reg_write;
        mem_read_p1  <= in_mem_read;
        mem_write_p1 <= in_mem_write;
      end else if (vld_p1) begin
        // Capture values retiring from WB so a stalled instruction does not lose them.
        if (wb_hit1) rs1_data_p1 <= wb_result;
        if (wb_hit2) rs2_data_p1 <= wb_result;
      end

      if (load_use) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the held instruction.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam logic [OPW-1:0] ALU_OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] ALU_OP_SUB = 4'b1000;

  logic clk, rst;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [OPW-1:0] in_alu_op;
  logic in_src1_pc, in_src2_imm, in_reg_write, in_mem_read, in_mem_write, flush;
  logic [4:0] mem_rd_addr, wb_rd_addr;
  logic mem_reg_write, mem_mem_read, wb_reg_write;
  logic [XLEN-1:0] mem_result, wb_result;
  logic out_valid, out_ready;
  logic [XLEN-1:0] alu_in1, alu_in2, out_pc, out_store_data;
  logic [OPW-1:0] alu_op;
  logic [4:0] out_rd_addr;
  logic out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .flush(flush), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction sitting in the stage.
  logic m_valid;
  logic [31:0] m_pc, m_d1, m_d2, m_imm, m_stalls;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [3:0] m_op;
  logic m_s1pc, m_s2imm, m_rw, m_mr, m_mw;

  logic exp_hz, exp_ov, exp_ir;
  logic [31:0] exp_a1, exp_a2, exp_sd;

  // Newest in-flight producer of register r wins; x0 is never produced.
  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] regfile_val);
    if (r != 0 && mem_reg_write && mem_rd_addr == r) return mem_result;
    if (r != 0 && wb_reg_write && wb_rd_addr == r) return wb_result;
    return regfile_val;
  endfunction

  task automatic model_eval();
    logic reads1, reads2, load_in_mem;
    reads1 = !m_s1pc;
    reads2 = !m_s2imm || m_mw;
    load_in_mem = mem_mem_read && mem_reg_write && mem_rd_addr != 0;
    exp_hz = m_valid && load_in_mem &&
             ((reads1 && mem_rd_addr == m_rs1) || (reads2 && mem_rd_addr == m_rs2));
    exp_ov = m_valid && !exp_hz;
    exp_ir = !m_valid || (exp_ov && out_ready);
    exp_sd = value_of(m_rs2, m_d2);
    exp_a1 = m_s1pc ? m_pc : value_of(m_rs1, m_d1);
    exp_a2 = m_s2imm ? m_imm : exp_sd;
  endtask

  task automatic tick();
    logic accept;
    model_eval();
    accept = in_valid && exp_ir;
    @(posedge clk);
    if (rst) begin
      {m_valid, m_pc, m_d1, m_d2, m_imm, m_stalls} = '0;
      {m_rs1, m_rs2, m_rd, m_op, m_s1pc, m_s2imm, m_rw, m_mr, m_mw} = '0;
    end else begin
      if (exp_hz) m_stalls = m_stalls + 1;
      if (accept && !flush) begin
        m_pc = in_pc; m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr;
        m_d1 = in_rs1_data; m_d2 = in_rs2_data; m_imm = in_imm; m_op = in_alu_op;
        m_s1pc = in_src1_pc; m_s2imm = in_src2_imm; m_rd = in_rd_addr;
        m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
      end else if (m_valid) begin
        if (wb_reg_write && wb_rd_addr == m_rs1 && m_rs1 != 0) m_d1 = wb_result;
        if (wb_reg_write && wb_rd_addr == m_rs2 && m_rs2 != 0) m_d2 = wb_result;
      end
      if (flush) m_valid = 1'b0;
      else if (accept) m_valid = 1'b1;
      else if (exp_ov && out_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [3:0] op, input logic s1pc, input logic s2imm,
                           input logic [4:0] rd, input logic mw);
    in_valid = 1'b1; in_pc = pc; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_alu_op = op;
    in_src1_pc = s1pc; in_src2_imm = s2imm; in_rd_addr = rd;
    in_reg_write = !mw; in_mem_read = 1'b0; in_mem_write = mw;
  endtask

  task automatic clear_fwd();
    mem_rd_addr = 0; mem_reg_write = 0; mem_mem_read = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic test_reset();
    in_valid = 0; flush = 0; out_ready = 0; clear_fwd();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    rst = 1; tick(); tick(); rst = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    vectors++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin miscompares++; $display("FAIL reset_alu_in got %h/%h want 0/0", alu_in1, alu_in2); end
    vectors++; if (alu_op !== 4'd0 || out_store_data !== 32'd0) begin miscompares++; $display("FAIL reset_op_sd got %h/%h want 0/0", alu_op, out_store_data); end
  endtask

  task automatic test_add();
    out_ready = 1;
    set_instr(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, ALU_OP_ADD, 0, 0, 5'd3, 0);
    tick(); in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    vectors++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin miscompares++; $display("FAIL add_operands got %0d/%0d want 5/7", alu_in1, alu_in2); end
    vectors++; if (alu_op !== ALU_OP_ADD || out_rd_addr !== 5'd3 || out_pc !== 32'h100) begin miscompares++; $display("FAIL add_sideband got op %h rd %0d pc %h want 0/3/100", alu_op, out_rd_addr, out_pc); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    out_ready = 1;
    set_instr(32'h140, 5'd4, 5'd0, 32'd1, 32'd0, 32'd0, ALU_OP_SUB, 0, 0, 5'd9, 0);
    tick(); in_valid = 0; out_ready = 0;
    mem_reg_write = 1; mem_rd_addr = 4; mem_result = 32'h22;
    wb_reg_write = 1; wb_rd_addr = 4; wb_result = 32'h33; #1;
    vectors++; if (alu_in1 !== 32'h22) begin miscompares++; $display("FAIL fwd_mem_prio got %h want 22", alu_in1); end
    mem_reg_write = 0; #1;
    vectors++; if (alu_in1 !== 32'h33) begin miscompares++; $display("FAIL fwd_wb got %h want 33", alu_in1); end
    mem_reg_write = 1; mem_rd_addr = 0; wb_rd_addr = 0; #1;
    vectors++; if (alu_in1 !== 32'd1) begin miscompares++; $display("FAIL fwd_x0 got %h want 1", alu_in1); end
    vectors++; if (alu_op !== ALU_OP_SUB) begin miscompares++; $display("FAIL fwd_op got %h want 8", alu_op); end
    clear_fwd(); out_ready = 1; tick();
  endtask

  task automatic test_load_use();
    out_ready = 1;
    set_instr(32'h180, 5'd6, 5'd5, 32'h10, 32'h11, 32'd0, ALU_OP_ADD, 0, 0, 5'd7, 0);
    tick(); in_valid = 0;
    mem_mem_read = 1; mem_reg_write = 1; mem_rd_addr = 5; mem_result = 32'hdead; #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall got v%b r%b want 0/0", out_valid, in_ready); end
    tick();
    vectors++; if (stall_cnt !== 32'd1) begin miscompares++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    clear_fwd(); wb_reg_write = 1; wb_rd_addr = 5; wb_result = 32'h99; out_ready = 0; #1;
    vectors++; if (out_valid !== 1'b1 || alu_in2 !== 32'h99) begin miscompares++; $display("FAIL lu_wb_fwd got v%b %h want 1/99", out_valid, alu_in2); end
    tick();
    wb_reg_write = 0; wb_result = 0; out_ready = 1; #1;
    vectors++; if (alu_in2 !== 32'h99 || out_store_data !== 32'h99) begin miscompares++; $display("FAIL lu_refresh got %h/%h want 99/99", alu_in2, out_store_data); end
    vectors++; if (stall_cnt !== 32'd1) begin miscompares++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    set_instr(32'h200, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, ALU_OP_ADD, 0, 0, 5'd10, 0);
    tick(); out_ready = 0;
    set_instr(32'h300, 5'd1, 5'd2, 32'd8, 32'd9, 32'd0, ALU_OP_SUB, 0, 0, 5'd11, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold%0d got r%b v%b want 0/1", i, in_ready, out_valid); end
      vectors++; if (out_pc !== 32'h200 || out_rd_addr !== 5'd10 || alu_op !== ALU_OP_ADD) begin miscompares++; $display("FAIL bp_stable%0d got %h/%0d want 200/10", i, out_pc, out_rd_addr); end
      tick();
    end
    out_ready = 1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready); end
    tick(); in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || alu_in1 !== 32'd8) begin miscompares++; $display("FAIL bp_next got v%b %h %0d want 1/300/8", out_valid, out_pc, alu_in1); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1; flush = 1;
    set_instr(32'h400, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, ALU_OP_ADD, 0, 0, 5'd12, 0); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", in_ready); end
    tick(); flush = 0; in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty got %b want 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_never got %b want 0", out_valid); end
    set_instr(32'h500, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, ALU_OP_ADD, 0, 0, 5'd13, 0);
    tick();
    set_instr(32'h600, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, ALU_OP_ADD, 0, 0, 5'd14, 0);
    flush = 1; tick(); flush = 0; in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_handoff got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = $urandom; in_imm = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom_range(0, 31)); in_alu_op = 4'($urandom_range(0, 15));
      in_src1_pc = ($urandom_range(0, 3) == 0); in_src2_imm = $urandom_range(0, 1) != 0;
      in_reg_write = $urandom_range(0, 1) != 0; in_mem_read = $urandom_range(0, 1) != 0;
      in_mem_write = $urandom_range(0, 1) != 0;
      flush = ($urandom_range(0, 15) == 0); out_ready = ($urandom_range(0, 3) != 0);
      mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = $urandom_range(0, 1) != 0;
      mem_mem_read = $urandom_range(0, 1) != 0; mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = $urandom_range(0, 1) != 0;
      wb_result = $urandom;
      #1; model_eval();
      vectors++; if (out_valid !== exp_ov) begin miscompares++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", i, out_valid, exp_ov); end
      vectors++; if (in_ready !== exp_ir) begin miscompares++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", i, in_ready, exp_ir); end
      vectors++; if (alu_in1 !== exp_a1) begin miscompares++; $display("FAIL rnd_alu_in1 cyc %0d got %h want %h", i, alu_in1, exp_a1); end
      vectors++; if (alu_in2 !== exp_a2) begin miscompares++; $display("FAIL rnd_alu_in2 cyc %0d got %h want %h", i, alu_in2, exp_a2); end
      vectors++; if (out_store_data !== exp_sd) begin miscompares++; $display("FAIL rnd_store_data cyc %0d got %h want %h", i, out_store_data, exp_sd); end
      vectors++; if (alu_op !== m_op) begin miscompares++; $display("FAIL rnd_alu_op cyc %0d got %h want %h", i, alu_op, m_op); end
      vectors++; if (out_pc !== m_pc || out_rd_addr !== m_rd) begin miscompares++; $display("FAIL rnd_pc_rd cyc %0d got %h/%0d want %h/%0d", i, out_pc, out_rd_addr, m_pc, m_rd); end
      vectors++; if ({out_reg_write, out_mem_read, out_mem_write} !== {m_rw, m_mr, m_mw}) begin miscompares++; $display("FAIL rnd_ctrl cyc %0d got %b%b%b want %b%b%b", i, out_reg_write, out_mem_read, out_mem_write, m_rw, m_mr, m_mw); end
      vectors++; if (stall_cnt !== m_stalls) begin miscompares++; $display("FAIL rnd_stall_cnt cyc %0d got %0d want %0d", i, stall_cnt, m_stalls); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
